// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gol_pkg
//  Description : Shared constants and helpers for the Game-of-Life engine:
//                FSM state encodings, Conway default rule masks, popcount.
//  Revision    : 1.0 - initial release
// ============================================================================
package gol_pkg;

    // FSM state encodings
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_SWAP = 2'd2;

    // Conway B3/S23: bit n of a mask selects neighbour count n
    localparam logic [8:0] c_BIRTH_B3    = 9'b000001000;
    localparam logic [8:0] c_SURVIVE_S23 = 9'b000001100;

    // Number of set bits in an 8-neighbour vector (0..8)
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gol_if.sv
`default_nettype none
// ============================================================================
//  Module      : gol_if
//  Description : Control, cell load/read and status bundle of the engine.
//                master = controller side, slave = engine side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gol_if #(
    parameter int WIDTH    = 10,
    parameter int HEIGHT   = 9,
    parameter int PERIOD_W = 25,
    parameter int SCORE_W  = 10
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic                run;
    logic                step;
    logic [PERIOD_W-1:0] period;
    logic                wr_en;
    logic [XW-1:0]       wr_x;
    logic [YW-1:0]       wr_y;
    logic                wr_val;
    logic [XW-1:0]       rd_x;
    logic [YW-1:0]       rd_y;
    logic                rd_cell;
    logic                busy;
    logic                gen_done;
    logic [31:0]         generation;
    logic                clr_score;
    logic [SCORE_W-1:0]  l_score;
    logic [SCORE_W-1:0]  r_score;

    modport master (
        output run, step, period, wr_en, wr_x, wr_y, wr_val, rd_x, rd_y, clr_score,
        input  rd_cell, busy, gen_done, generation, l_score, r_score
    );

    modport slave (
        input  run, step, period, wr_en, wr_x, wr_y, wr_val, rd_x, rd_y, clr_score,
        output rd_cell, busy, gen_done, generation, l_score, r_score
    );

endinterface
`default_nettype wire

// File: rtl/gol_cell_rule.sv
`default_nettype none
// ============================================================================
//  Module      : gol_cell_rule
//  Description : Next state of one cell from its 8 neighbours and the
//                birth/survive masks.
//  Revision    : 1.0 - initial release
// ============================================================================
module gol_cell_rule
    import gol_pkg::*;
(
    input  wire logic [7:0] i_nbrs,
    input  wire logic       i_cell,
    input  wire logic [8:0] i_birth_mask,
    input  wire logic [8:0] i_survive_mask,
    output logic            o_next
);

    logic [3:0] w_count;

    assign w_count = popcount8(i_nbrs);
    assign o_next  = i_cell ? i_survive_mask[w_count] : i_birth_mask[w_count];

endmodule
`default_nettype wire

// File: rtl/gol_engine.sv
`default_nettype none
// ============================================================================
//  Module      : gol_engine
//  Description : Game-of-Life engine. One board row per clock is computed
//                into a shadow board, which replaces the current board in a
//                single swap cycle. Goal-column scores accumulate per swap.
//  Revision    : 1.0 - initial release
// ============================================================================
module gol_engine
    import gol_pkg::*;
#(
    parameter int                WIDTH        = 10,
    parameter int                HEIGHT       = 9,
    parameter int                WRAP         = 0,
    parameter logic [8:0]        BIRTH_MASK   = c_BIRTH_B3,
    parameter logic [8:0]        SURVIVE_MASK = c_SURVIVE_S23,
    parameter logic [HEIGHT-1:0] GOAL_ROWS    = {HEIGHT{1'b1}},
    parameter int                PERIOD_W     = 25,
    parameter int                SCORE_W      = 10
) (
    input wire logic clk,
    input wire logic rst,
    gol_if.slave     bus
);

    localparam int CELLS = WIDTH * HEIGHT;
    localparam int YW    = $clog2(HEIGHT);

    logic [1:0]          state_q, state_d;
    logic [PERIOD_W-1:0] tick_q, tick_d;
    logic [YW-1:0]       row_q, row_d;
    logic [CELLS-1:0]    cur_q, cur_d;
    logic [CELLS-1:0]    shd_q, shd_d;
    logic [31:0]         gen_q, gen_d;
    logic [SCORE_W-1:0]  l_score_q, l_score_d;
    logic [SCORE_W-1:0]  r_score_q, r_score_d;

    logic [PERIOD_W-1:0] w_tick_max;
    logic [WIDTH-1:0]    w_row_above, w_row_mid, w_row_below, w_next_row;
    logic [WIDTH+1:0]    w_ext_above, w_ext_mid, w_ext_below;
    int                  w_l_cnt, w_r_cnt;
    logic                w_rd_cell;

    // Bit 0 is column -1 and bit WIDTH+1 is column WIDTH; they hold the
    // wrapped-around column on a torus and are dead otherwise.
    function automatic logic [WIDTH+1:0] pad_row(input logic [WIDTH-1:0] r);
        logic lo, hi;
        lo = (WRAP != 0) ? r[WIDTH-1] : 1'b0;
        hi = (WRAP != 0) ? r[0]       : 1'b0;
        return {hi, r, lo};
    endfunction

    // Add a count to a score, clamping at the all-ones value
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input int b);
        int s;
        int mx;
        mx = (1 << SCORE_W) - 1;
        s  = int'(a) + b;
        if (s > mx) begin
            s = mx;
        end
        return s[SCORE_W-1:0];
    endfunction

    assign w_tick_max = (bus.period == '0) ? '0 : bus.period - PERIOD_W'(1);

    // Fetch the row being computed and its vertical neighbours from the current board
    always_comb begin
        w_row_mid   = cur_q[int'(row_q)*WIDTH +: WIDTH];
        w_row_above = '0;
        w_row_below = '0;
        if (row_q != '0) begin
            w_row_above = cur_q[(int'(row_q)-1)*WIDTH +: WIDTH];
        end else if (WRAP != 0) begin
            w_row_above = cur_q[(HEIGHT-1)*WIDTH +: WIDTH];
        end
        if (int'(row_q) != HEIGHT-1) begin
            w_row_below = cur_q[(int'(row_q)+1)*WIDTH +: WIDTH];
        end else if (WRAP != 0) begin
            w_row_below = cur_q[0 +: WIDTH];
        end
    end

    assign w_ext_above = pad_row(w_row_above);
    assign w_ext_mid   = pad_row(w_row_mid);
    assign w_ext_below = pad_row(w_row_below);

    for (genvar x = 0; x < WIDTH; x++) begin : g_col
        gol_cell_rule u_rule (
            .i_nbrs         ({w_ext_above[x+2:x], w_ext_mid[x+2], w_ext_mid[x], w_ext_below[x+2:x]}),
            .i_cell         (w_row_mid[x]),
            .i_birth_mask   (BIRTH_MASK),
            .i_survive_mask (SURVIVE_MASK),
            .o_next         (w_next_row[x])
        );
    end

    // Live goal cells on the finished shadow board, per edge column
    always_comb begin
        w_l_cnt = 0;
        w_r_cnt = 0;
        for (int y = 0; y < HEIGHT; y++) begin
            if (GOAL_ROWS[y]) begin
                w_r_cnt = w_r_cnt + (shd_q[y*WIDTH] ? 1 : 0);
                w_l_cnt = w_l_cnt + (shd_q[y*WIDTH + WIDTH - 1] ? 1 : 0);
            end
        end
    end

    // Control FSM, cell writes, row commits, swap and score update
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        row_d     = row_q;
        cur_d     = cur_q;
        shd_d     = shd_q;
        gen_d     = gen_q;
        l_score_d = l_score_q;
        r_score_d = r_score_q;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.wr_en) begin
                    // A write claims the cycle: no generation may start
                    if (int'(bus.wr_x) < WIDTH && int'(bus.wr_y) < HEIGHT) begin
                        cur_d[int'(bus.wr_y)*WIDTH + int'(bus.wr_x)] = bus.wr_val;
                    end
                end else if (bus.run) begin
                    if (tick_q == w_tick_max) begin
                        tick_d  = '0;
                        row_d   = '0;
                        state_d = c_ST_CALC;
                    end else begin
                        tick_d = tick_q + PERIOD_W'(1);
                    end
                end else if (bus.step) begin
                    row_d   = '0;
                    state_d = c_ST_CALC;
                end
            end
            c_ST_CALC: begin
                shd_d[int'(row_q)*WIDTH +: WIDTH] = w_next_row;
                if (int'(row_q) == HEIGHT-1) begin
                    state_d = c_ST_SWAP;
                end else begin
                    row_d = row_q + YW'(1);
                end
            end
            c_ST_SWAP: begin
                cur_d     = shd_q;
                gen_d     = gen_q + 32'd1;
                l_score_d = sat_add(l_score_q, w_l_cnt);
                r_score_d = sat_add(r_score_q, w_r_cnt);
                row_d     = '0;
                state_d   = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
        if (bus.clr_score) begin
            l_score_d = '0;
            r_score_d = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_ST_IDLE;
            tick_q    <= '0;
            row_q     <= '0;
            cur_q     <= '0;
            shd_q     <= '0;
            gen_q     <= '0;
            l_score_q <= '0;
            r_score_q <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            row_q     <= row_d;
            cur_q     <= cur_d;
            shd_q     <= shd_d;
            gen_q     <= gen_d;
            l_score_q <= l_score_d;
            r_score_q <= r_score_d;
        end
    end

    // Zero-latency read port; out-of-range coordinates read as dead
    always_comb begin
        w_rd_cell = 1'b0;
        if (int'(bus.rd_x) < WIDTH && int'(bus.rd_y) < HEIGHT) begin
            w_rd_cell = cur_q[int'(bus.rd_y)*WIDTH + int'(bus.rd_x)];
        end
    end

    assign bus.rd_cell    = w_rd_cell;
    assign bus.busy       = (state_q != c_ST_IDLE);
    assign bus.gen_done   = (state_q == c_ST_SWAP);
    assign bus.generation = gen_q;
    assign bus.l_score    = l_score_q;
    assign bus.r_score    = r_score_q;

endmodule
`default_nettype wire

// File: tb/tb_gol_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gol_engine
//  Description : Directed bench for gol_engine. Three engines share stimulus:
//                A dead-edge with split goal rows, B toroidal, C dead-edge
//                with a 3-bit score.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gol_engine;

    localparam int W  = 10;
    localparam int H  = 9;
    localparam int NC = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        run, step, clr_score, wr_en, wr_val;
    logic [24:0] period;
    logic [3:0]  wr_x, wr_y, rd_x, rd_y;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gol_if #(.WIDTH(W), .HEIGHT(H), .PERIOD_W(25), .SCORE_W(10)) if_a ();
    gol_if #(.WIDTH(W), .HEIGHT(H), .PERIOD_W(25), .SCORE_W(10)) if_b ();
    gol_if #(.WIDTH(W), .HEIGHT(H), .PERIOD_W(25), .SCORE_W(3))  if_c ();

    assign if_a.run = run;       assign if_b.run = run;       assign if_c.run = run;
    assign if_a.step = step;     assign if_b.step = step;     assign if_c.step = step;
    assign if_a.period = period; assign if_b.period = period; assign if_c.period = period;
    assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;   assign if_c.wr_en = wr_en;
    assign if_a.wr_x = wr_x;     assign if_b.wr_x = wr_x;     assign if_c.wr_x = wr_x;
    assign if_a.wr_y = wr_y;     assign if_b.wr_y = wr_y;     assign if_c.wr_y = wr_y;
    assign if_a.wr_val = wr_val; assign if_b.wr_val = wr_val; assign if_c.wr_val = wr_val;
    assign if_a.rd_x = rd_x;     assign if_b.rd_x = rd_x;     assign if_c.rd_x = rd_x;
    assign if_a.rd_y = rd_y;     assign if_b.rd_y = rd_y;     assign if_c.rd_y = rd_y;
    assign if_a.clr_score = clr_score;
    assign if_b.clr_score = clr_score;
    assign if_c.clr_score = clr_score;

    gol_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(0), .GOAL_ROWS(9'b111000111),
                 .PERIOD_W(25), .SCORE_W(10)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    gol_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1),
                 .PERIOD_W(25), .SCORE_W(10)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    gol_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(0), .GOAL_ROWS(9'b111000111),
                 .PERIOD_W(25), .SCORE_W(3))  u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx(input int y, input int x);
        return y * W + x;
    endfunction

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick_clk();
        tick_clk();
        rst = 1'b0;
    endtask

    task automatic wr(input int y, input int x, input logic v);
        wr_en  = 1'b1;
        wr_y   = 4'(y);
        wr_x   = 4'(x);
        wr_val = v;
        tick_clk();
        wr_en  = 1'b0;
    endtask

    task automatic read_boards(output logic [NC-1:0] ba, output logic [NC-1:0] bb,
                               output logic [NC-1:0] bc);
        ba = '0;
        bb = '0;
        bc = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                rd_y = 4'(y);
                rd_x = 4'(x);
                #1;
                ba[idx(y, x)] = if_a.rd_cell;
                bb[idx(y, x)] = if_b.rd_cell;
                bc[idx(y, x)] = if_c.rd_cell;
            end
        end
    endtask

    // Leaves time at the sample where gen_done is high (SWAP cycle)
    task automatic wait_pulse(input string tag);
        int n;
        n = 0;
        while (if_a.gen_done !== 1'b1 && n < 40) begin
            tick_clk();
            n++;
        end
        if (if_a.gen_done !== 1'b1) begin
            check({tag, "_timeout"}, 128'(if_a.gen_done), 128'd1);
        end
    endtask

    task automatic do_step(input string tag);
        step = 1'b1;
        tick_clk();
        step = 1'b0;
        wait_pulse(tag);
        tick_clk();
    endtask

    task automatic measure(output int n);
        n = 0;
        do begin
            tick_clk();
            n++;
        end while (if_a.gen_done !== 1'b1 && n < 100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [NC-1:0] ba, bb, bc, exp_b, glider;
        int n;

        run = 0; step = 0; clr_score = 0; wr_en = 0; wr_val = 0;
        period = '0; wr_x = '0; wr_y = '0; rd_x = '0; rd_y = '0;
        do_reset();

        check("rst_busy", if_a.busy, 1'b0);
        check("rst_gen_done", if_a.gen_done, 1'b0);
        check("rst_generation", if_a.generation, 32'd0);
        check("rst_scores", {if_a.l_score, if_a.r_score}, 20'd0);
        read_boards(ba, bb, bc);
        check("rst_board", ba, '0);

        // Blinker
        wr(4, 3, 1'b1); wr(4, 4, 1'b1); wr(4, 5, 1'b1);
        exp_b = '0;
        exp_b[idx(4, 3)] = 1'b1; exp_b[idx(4, 4)] = 1'b1; exp_b[idx(4, 5)] = 1'b1;
        read_boards(ba, bb, bc);
        check("blinker_load", ba, exp_b);
        step = 1'b1;
        tick_clk();
        step = 1'b0;
        check("busy_in_calc", if_a.busy, 1'b1);
        wait_pulse("blinker1");
        tick_clk();
        exp_b = '0;
        exp_b[idx(3, 4)] = 1'b1; exp_b[idx(4, 4)] = 1'b1; exp_b[idx(5, 4)] = 1'b1;
        read_boards(ba, bb, bc);
        check("blinker_vertical", ba, exp_b);
        check("blinker_vertical_wrap", bb, exp_b);
        do_step("blinker2");
        exp_b = '0;
        exp_b[idx(4, 3)] = 1'b1; exp_b[idx(4, 4)] = 1'b1; exp_b[idx(4, 5)] = 1'b1;
        read_boards(ba, bb, bc);
        check("blinker_back", ba, exp_b);
        check("blinker_generation", if_a.generation, 32'd2);

        // Out-of-range read and write
        rd_x = 4'd10; rd_y = 4'd4; #1;
        check("rd_oor_x", if_a.rd_cell, 1'b0);
        rd_x = 4'd4; rd_y = 4'd9; #1;
        check("rd_oor_y", if_a.rd_cell, 1'b0);
        wr(4, 10, 1'b1);
        wr(9, 0, 1'b1);
        read_boards(ba, bb, bc);
        check("wr_oor_ignored", ba, exp_b);

        // A write in IDLE drops a simultaneous step but still commits
        step = 1'b1; wr_en = 1'b1; wr_x = 4'd0; wr_y = 4'd0; wr_val = 1'b1;
        tick_clk();
        step = 1'b0; wr_en = 1'b0;
        tick_clk();
        check("step_blocked_by_wr", if_a.busy, 1'b0);
        exp_b[idx(0, 0)] = 1'b1;
        read_boards(ba, bb, bc);
        check("wr_commits_with_step", ba, exp_b);
        wr(0, 0, 1'b0);

        // Write and step during CALC are ignored
        step = 1'b1;
        tick_clk();
        step = 1'b0;
        wr_en = 1'b1; wr_x = 4'd0; wr_y = 4'd0; wr_val = 1'b1; step = 1'b1;
        tick_clk();
        wr_en = 1'b0; step = 1'b0;
        wait_pulse("calc_ignore");
        tick_clk();
        tick_clk();
        tick_clk();
        check("step_in_calc_ignored", if_a.busy, 1'b0);
        check("calc_ignore_generation", if_a.generation, 32'd3);
        exp_b = '0;
        exp_b[idx(3, 4)] = 1'b1; exp_b[idx(4, 4)] = 1'b1; exp_b[idx(5, 4)] = 1'b1;
        read_boards(ba, bb, bc);
        check("wr_in_calc_ignored", ba, exp_b);

        // Free-running spacing: period+HEIGHT+1, period 0 behaves as 1
        period = 25'd3;
        run = 1'b1;
        wait_pulse("run_first");
        measure(n);
        check("spacing_period3", n, 13);
        period = 25'd0;
        measure(n);
        check("spacing_period0", n, 11);
        run = 1'b0;
        tick_clk();
        tick_clk();
        check("run_stopped", if_a.busy, 1'b0);

        // Glider: returns home on the torus, settles into a block with dead edges
        do_reset();
        glider = '0;
        glider[idx(6, 6)] = 1'b1; glider[idx(7, 7)] = 1'b1;
        glider[idx(8, 5)] = 1'b1; glider[idx(8, 6)] = 1'b1; glider[idx(8, 7)] = 1'b1;
        wr(6, 6, 1'b1); wr(7, 7, 1'b1); wr(8, 5, 1'b1); wr(8, 6, 1'b1); wr(8, 7, 1'b1);
        for (int g = 0; g < 360; g++) begin
            do_step("glider");
        end
        exp_b = '0;
        exp_b[idx(7, 6)] = 1'b1; exp_b[idx(7, 7)] = 1'b1;
        exp_b[idx(8, 6)] = 1'b1; exp_b[idx(8, 7)] = 1'b1;
        read_boards(ba, bb, bc);
        check("glider_torus_home", bb, glider);
        check("glider_dead_edge_block", ba, exp_b);
        check("glider_dead_edge_block_c", bc, exp_b);
        check("glider_generation", if_b.generation, 32'd360);

        // Scores from a corner block
        do_reset();
        wr(0, 0, 1'b1); wr(0, 1, 1'b1); wr(1, 0, 1'b1); wr(1, 1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            do_step("score");
            check($sformatf("r_score_gen%0d", k), if_a.r_score, 10'(2 * k));
            check($sformatf("r_score_sat_gen%0d", k), if_c.r_score, (2 * k > 7) ? 3'd7 : 3'(2 * k));
        end
        check("l_score_zero", if_a.l_score, 10'd0);
        step = 1'b1;
        tick_clk();
        step = 1'b0;
        wait_pulse("clr_swap");
        clr_score = 1'b1;
        tick_clk();
        clr_score = 1'b0;
        check("clr_wins_over_swap", if_a.r_score, 10'd0);
        check("clr_wins_over_swap_c", if_c.r_score, 3'd0);
        check("clr_generation", if_a.generation, 32'd6);

        // Reset in the middle of CALC
        step = 1'b1;
        tick_clk();
        step = 1'b0;
        tick_clk();
        tick_clk();
        check("mid_calc_busy", if_a.busy, 1'b1);
        rst = 1'b1;
        tick_clk();
        check("rst_mid_calc_busy", if_a.busy, 1'b0);
        rst = 1'b0;
        tick_clk();
        read_boards(ba, bb, bc);
        check("rst_mid_calc_board", ba, '0);
        check("rst_mid_calc_generation", if_a.generation, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
